// File: rtl/mvau_hs_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mvau_hs_pkg                                                      |
// | Shared defaults, derived sizes, FSM state type and sign helpers. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mvau_hs_pkg;

    // Width of a counter or address that must hold values 0..n-1, never below 1.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int unsigned w);
        logic [31:0] sh;
        sh = v << (32 - w);
        return $signed(sh) >>> (32 - w);
    endfunction

    localparam int SIMD_D    = 2;
    localparam int PE_D      = 2;
    localparam int MATRIXW_D = 4;
    localparam int MATRIXH_D = 4;
    localparam int TSRCI_D   = 4;
    localparam int TW_D      = 4;
    localparam int TDSTI_D   = 16;

    localparam int SF_D = MATRIXW_D / SIMD_D;
    localparam int NF_D = MATRIXH_D / PE_D;
    localparam int TI_D = TSRCI_D * SIMD_D;
    localparam int TO_D = TDSTI_D * PE_D;
    localparam int WA_D = cnt_width(SF_D * NF_D);

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mvau_hs_pe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mvau_hs_pe                                                       |
// | One output lane: SIMD signed products, adder tree, accumulator.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mvau_hs_pe
    import mvau_hs_pkg::*;
#(
    parameter int SIMD  = SIMD_D,
    parameter int TSrcI = TSRCI_D,
    parameter int TW    = TW_D,
    parameter int TDstI = TDSTI_D
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    first,
    input  logic [SIMD*TSrcI-1:0]   act,
    input  logic [SIMD*TW-1:0]      w,
    output logic [TDstI-1:0]        acc_next
);

    logic [TDstI-1:0] sum;
    logic [TDstI-1:0] acc_d;
    logic [TDstI-1:0] acc_q;

    // Products are formed at 32 bits and truncated; the sum wraps modulo 2^TDstI.
    always_comb begin
        sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            sum = sum + TDstI'(sext(32'(act[i*TSrcI +: TSrcI]), TSrcI)
                             * sext(32'(w[i*TW +: TW]), TW));
        end
        acc_next = first ? sum : acc_q + sum;
        acc_d    = en ? acc_next : acc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mvau_hs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mvau_hs                                                          |
// | Matrix-vector activation unit with ready/valid streams and an    |
// | input buffer replayed across row-folds.                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mvau_hs
    import mvau_hs_pkg::*;
#(
    parameter int SIMD    = SIMD_D,
    parameter int PE      = PE_D,
    parameter int MatrixW = MATRIXW_D,
    parameter int MatrixH = MATRIXH_D,
    parameter int TSrcI   = TSRCI_D,
    parameter int TW      = TW_D,
    parameter int TDstI   = TDSTI_D
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic [TSrcI*SIMD-1:0]                                  in,
    input  logic                                                   in_v,
    output logic                                                   in_rdy,
    output logic [cnt_width((MatrixW/SIMD)*(MatrixH/PE))-1:0]      wmem_addr,
    output logic                                                   wmem_ren,
    input  logic [PE*SIMD*TW-1:0]                                  wmem_data,
    output logic [TDstI*PE-1:0]                                    out,
    output logic                                                   out_v,
    input  logic                                                   out_rdy
);

    localparam int SF  = MatrixW / SIMD;
    localparam int NF  = MatrixH / PE;
    localparam int TI  = TSrcI * SIMD;
    localparam int TO  = TDstI * PE;
    localparam int WA  = cnt_width(SF * NF);
    localparam int SFW = cnt_width(SF);
    localparam int NFW = cnt_width(NF);

    state_e           state_q, state_d;
    logic [SFW-1:0]   sf_q, sf_d;
    logic [NFW-1:0]   nf_q, nf_d;
    logic [WA-1:0]    addr_q, addr_d;
    logic             s1_v_q, s1_v_d;
    logic             s1_first_q, s1_first_d;
    logic             s1_last_q, s1_last_d;
    logic [TI-1:0]    s1_act_q, s1_act_d;
    logic             out_v_q, out_v_d;
    logic [TO-1:0]    out_q, out_d;
    logic [TO-1:0]    acc_next;
    logic [TI-1:0]    ibuf_q [SF];

    logic en;
    logic issue;
    logic last_sf;
    logic acc_en;

    always_comb begin
        en      = !out_v_q || out_rdy;
        in_rdy  = rst_n && en && (state_q == FILL);
        issue   = rst_n && en && ((state_q == FILL) ? in_v : 1'b1);
        last_sf = (sf_q == SFW'(SF - 1));
        acc_en  = en && s1_v_q;

        state_d = state_q;
        sf_d    = sf_q;
        nf_d    = nf_q;
        if (issue) begin
            if (last_sf) begin
                sf_d = '0;
                if (nf_q == NFW'(NF - 1)) begin
                    nf_d    = '0;
                    state_d = FILL;
                end else begin
                    nf_d    = nf_q + NFW'(1);
                    state_d = REPLAY;
                end
            end else begin
                sf_d = sf_q + SFW'(1);
            end
        end

        // Address is held between issues so the port stays quiet during stalls.
        addr_d    = issue ? (WA'(nf_q) * WA'(SF) + WA'(sf_q)) : addr_q;
        wmem_addr = rst_n ? addr_d : '0;
        wmem_ren  = issue;

        s1_v_d     = s1_v_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_act_d   = s1_act_q;
        if (en) begin
            s1_v_d     = issue;
            s1_first_d = (sf_q == '0);
            s1_last_d  = last_sf;
            s1_act_d   = (state_q == FILL) ? in : ibuf_q[sf_q];
        end

        out_v_d = en ? (s1_v_q && s1_last_q) : out_v_q;
        out_d   = (acc_en && s1_last_q) ? acc_next : out_q;

        out   = out_q;
        out_v = out_v_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            sf_q       <= '0;
            nf_q       <= '0;
            addr_q     <= '0;
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_act_q   <= '0;
            out_v_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            sf_q       <= sf_d;
            nf_q       <= nf_d;
            addr_q     <= addr_d;
            s1_v_q     <= s1_v_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_act_q   <= s1_act_d;
            out_v_q    <= out_v_d;
            out_q      <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_rdy && in_v) begin
            ibuf_q[sf_q] <= in;
        end
    end

    for (genvar p = 0; p < PE; p++) begin : g_pe
        mvau_hs_pe #(
            .SIMD  (SIMD),
            .TSrcI (TSrcI),
            .TW    (TW),
            .TDstI (TDstI)
        ) u_pe (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (acc_en),
            .first    (s1_first_q),
            .act      (s1_act_q),
            .w        (wmem_data[p*SIMD*TW +: SIMD*TW]),
            .acc_next (acc_next[p*TDstI +: TDstI])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_mvau_hs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mvau_hs                                                       |
// | Directed bench: default unit, an NF=1 unit and an 8-bit unit.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mvau_hs;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // Default configuration: SIMD=2 PE=2 4x4, 4/4/16 bits
    logic [7:0]  a_in;
    logic        a_in_v, a_in_rdy, a_ren, a_out_v, a_out_rdy;
    logic [1:0]  a_addr;
    logic [15:0] a_wdata;
    logic [31:0] a_out;
    logic [15:0] a_mem [4];
    logic [31:0] a_got [$];

    // NF=1 configuration (MatrixH=2)
    logic [7:0]  b_in;
    logic        b_in_v, b_in_rdy, b_ren, b_out_v, b_out_rdy;
    logic [0:0]  b_addr;
    logic [15:0] b_wdata;
    logic [31:0] b_out;
    logic [15:0] b_mem [2];

    // 8-bit configuration
    logic [15:0] c_in;
    logic        c_in_v, c_in_rdy, c_ren, c_out_v, c_out_rdy;
    logic [1:0]  c_addr;
    logic [31:0] c_wdata;
    logic [15:0] c_out;
    logic [31:0] c_mem [4];

    int wm [4][4];

    mvau_hs u_a (
        .clk(clk), .rst_n(rst_n), .in(a_in), .in_v(a_in_v), .in_rdy(a_in_rdy),
        .wmem_addr(a_addr), .wmem_ren(a_ren), .wmem_data(a_wdata),
        .out(a_out), .out_v(a_out_v), .out_rdy(a_out_rdy)
    );

    mvau_hs #(.MatrixH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .in_v(b_in_v), .in_rdy(b_in_rdy),
        .wmem_addr(b_addr), .wmem_ren(b_ren), .wmem_data(b_wdata),
        .out(b_out), .out_v(b_out_v), .out_rdy(b_out_rdy)
    );

    mvau_hs #(.TSrcI(8), .TW(8), .TDstI(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in(c_in), .in_v(c_in_v), .in_rdy(c_in_rdy),
        .wmem_addr(c_addr), .wmem_ren(c_ren), .wmem_data(c_wdata),
        .out(c_out), .out_v(c_out_v), .out_rdy(c_out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (a_ren) a_wdata <= a_mem[a_addr];
    always @(posedge clk) if (b_ren) b_wdata <= b_mem[b_addr];
    always @(posedge clk) if (c_ren) c_wdata <= c_mem[c_addr];

    // Record every accepted output word of the default unit.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && a_out_v && a_out_rdy) a_got.push_back(a_out);
    end

    task automatic build_a();
        for (int nf = 0; nf < 2; nf++)
            for (int sf = 0; sf < 2; sf++)
                for (int p = 0; p < 2; p++)
                    for (int i = 0; i < 2; i++)
                        a_mem[nf*2+sf][(p*2+i)*4 +: 4] = 4'(wm[nf*2+p][sf*2+i]);
    endtask

    task automatic build_b();
        for (int sf = 0; sf < 2; sf++)
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < 2; i++)
                    b_mem[sf][(p*2+i)*4 +: 4] = 4'(wm[p][sf*2+i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        a_in_v = 1'b0;
        b_in_v = 1'b0;
        c_in_v = 1'b0;
        a_out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_got.delete();
    endtask

    task automatic wait_a(input int n);
        int cyc = 0;
        while (a_got.size() < n && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy got %b want 0", a_in_rdy); end
        checks++; if (a_out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got %b want 0", a_out_v); end
        checks++; if (a_out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", a_out); end
        checks++; if (a_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", a_ren); end
        checks++; if (a_addr !== 2'd0) begin errors++; $display("FAIL reset_addr got %h want 0", a_addr); end
        checks++; if (b_in_rdy !== 1'b0 || c_in_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_bc got %b%b want 00", b_in_rdy, c_in_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit          exp_rdy [6] = '{1, 1, 0, 0, 1, 1};
        bit          exp_ren [6] = '{1, 1, 1, 1, 0, 0};
        bit          exp_ov  [6] = '{0, 0, 0, 1, 0, 1};
        logic [31:0] exp_out [6] = '{0, 0, 0, 32'h0001_000A, 0, 32'h0014_0002};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_in_v = (k < 2);
            a_in   = (k == 0) ? 8'h21 : 8'h43;
            #1;
            checks++; if (a_in_rdy !== exp_rdy[k]) begin errors++; $display("FAIL basic_in_rdy c%0d got %b want %b", k, a_in_rdy, exp_rdy[k]); end
            checks++; if (a_ren !== exp_ren[k]) begin errors++; $display("FAIL basic_ren c%0d got %b want %b", k, a_ren, exp_ren[k]); end
            checks++; if (a_out_v !== exp_ov[k]) begin errors++; $display("FAIL basic_out_v c%0d got %b want %b", k, a_out_v, exp_ov[k]); end
            if (exp_ov[k]) begin
                checks++; if (a_out !== exp_out[k]) begin errors++; $display("FAIL basic_out c%0d got %h want %h", k, a_out, exp_out[k]); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_in_v = (k < 2);
            a_in   = (k == 0) ? 8'h21 : 8'h43;
        end
        for (int k = 3; k < 8; k++) begin
            @(negedge clk);
            a_in_v    = 1'b0;
            a_out_rdy = 1'b0;
            #1;
            checks++; if (a_out_v !== 1'b1) begin errors++; $display("FAIL bp_out_v c%0d got %b want 1", k, a_out_v); end
            checks++; if (a_out !== 32'h0001_000A) begin errors++; $display("FAIL bp_out_hold c%0d got %h want 0001000a", k, a_out); end
            checks++; if (a_ren !== 1'b0) begin errors++; $display("FAIL bp_ren c%0d got %b want 0", k, a_ren); end
            checks++; if (a_in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy c%0d got %b want 0", k, a_in_rdy); end
        end
        @(negedge clk);
        a_out_rdy = 1'b1;
        wait_a(2);
        checks++; if (a_got.size() !== 2) begin errors++; $display("FAIL bp_count got %0d want 2", a_got.size()); end
        if (a_got.size() >= 2) begin
            checks++; if (a_got[0] !== 32'h0001_000A) begin errors++; $display("FAIL bp_first got %h want 0001000a", a_got[0]); end
            checks++; if (a_got[1] !== 32'h0014_0002) begin errors++; $display("FAIL bp_second got %h want 00140002", a_got[1]); end
        end
    endtask

    task automatic test_gaps();
        bit         vld [4] = '{1, 0, 1, 0};
        logic [7:0] dat [4] = '{8'h21, 8'hFF, 8'h43, 8'hFF};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_in_v = vld[k];
            a_in   = dat[k];
            #1;
            if (k == 1) begin
                checks++; if (a_ren !== 1'b0) begin errors++; $display("FAIL gap_ren got %b want 0", a_ren); end
            end
        end
        wait_a(2);
        checks++; if (a_got.size() !== 2) begin errors++; $display("FAIL gap_count got %0d want 2", a_got.size()); end
        if (a_got.size() >= 2) begin
            checks++; if (a_got[0] !== 32'h0001_000A) begin errors++; $display("FAIL gap_first got %h want 0001000a", a_got[0]); end
            checks++; if (a_got[1] !== 32'h0014_0002) begin errors++; $display("FAIL gap_second got %h want 00140002", a_got[1]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a_in_v = 1'b1;
            a_in   = (k == 0) ? 8'h21 : 8'h43;
        end
        @(negedge clk);
        a_in_v = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (a_out_v !== 1'b0) begin errors++; $display("FAIL rmid_out_v got %b want 0", a_out_v); end
        checks++; if (a_in_rdy !== 1'b0) begin errors++; $display("FAIL rmid_in_rdy got %b want 0", a_in_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
        a_got.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a_in_v = 1'b1;
            a_in   = 8'h11;
            #1;
            checks++; if (a_in_rdy !== 1'b1) begin errors++; $display("FAIL rmid_fresh_rdy w%0d got %b want 1", k, a_in_rdy); end
        end
        @(negedge clk);
        a_in_v = 1'b0;
        wait_a(2);
        checks++; if (a_got.size() !== 2) begin errors++; $display("FAIL rmid_count got %0d want 2", a_got.size()); end
        if (a_got.size() >= 2) begin
            checks++; if (a_got[0] !== 32'h0001_0004) begin errors++; $display("FAIL rmid_first got %h want 00010004", a_got[0]); end
            checks++; if (a_got[1] !== 32'h0008_0001) begin errors++; $display("FAIL rmid_second got %h want 00080001", a_got[1]); end
        end
    endtask

    task automatic test_signed();
        for (int a = 0; a < 4; a++) a_mem[a] = 16'h3333;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_in_v = (k < 2);
            a_in   = 8'hFF;
        end
        a_in_v = 1'b0;
        wait_a(2);
        checks++; if (a_got.size() !== 2) begin errors++; $display("FAIL signed_count got %0d want 2", a_got.size()); end
        if (a_got.size() >= 2) begin
            checks++; if (a_got[0] !== 32'hFFF4_FFF4) begin errors++; $display("FAIL signed_first got %h want fff4fff4", a_got[0]); end
            checks++; if (a_got[1] !== 32'hFFF4_FFF4) begin errors++; $display("FAIL signed_second got %h want fff4fff4", a_got[1]); end
        end
    endtask

    task automatic test_nf1_back_to_back();
        logic [7:0]  wrd     [9] = '{8'h11, 8'h11, 8'h21, 8'h43, 8'hEF, 8'h50, 8'h00, 8'h00, 8'h00};
        bit          exp_ov  [9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
        logic [31:0] exp_out [9] = '{0, 0, 0, 32'h0000_000A, 0, 32'hFFFE_001E, 0, 32'hFFFC_000F, 0};
        wm = '{'{1, 2, 3, 4}, '{1, -1, 1, -1}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        build_b();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            b_in_v = (k < 6);
            b_in   = wrd[k];
            #1;
            checks++; if (b_in_rdy !== 1'b1) begin errors++; $display("FAIL nf1_in_rdy c%0d got %b want 1", k, b_in_rdy); end
            checks++; if (b_out_v !== exp_ov[k]) begin errors++; $display("FAIL nf1_out_v c%0d got %b want %b", k, b_out_v, exp_ov[k]); end
            if (exp_ov[k]) begin
                checks++; if (b_out !== exp_out[k]) begin errors++; $display("FAIL nf1_out c%0d got %h want %h", k, b_out, exp_out[k]); end
            end
        end
        b_in_v = 1'b0;
    endtask

    task automatic test_wrap();
        int          vals [2] = '{7, 100};
        logic [15:0] exps [2] = '{16'hC4C4, 16'h4040};
        for (int t = 0; t < 2; t++) begin
            int sent = 0;
            int got  = 0;
            for (int a = 0; a < 4; a++) c_mem[a] = {4{8'(vals[t])}};
            do_reset();
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                c_in_v = (sent < 2);
                c_in   = {2{8'(vals[t])}};
                #1;
                if (c_in_v && c_in_rdy) sent++;
                if (c_out_v) begin
                    got++;
                    checks++; if (c_out !== exps[t]) begin errors++; $display("FAIL wrap_out v%0d got %h want %h", vals[t], c_out, exps[t]); end
                end
            end
            c_in_v = 1'b0;
            checks++; if (got !== 2) begin errors++; $display("FAIL wrap_count v%0d got %0d want 2", vals[t], got); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in = '0; a_in_v = 1'b0; a_out_rdy = 1'b1;
        b_in = '0; b_in_v = 1'b0; b_out_rdy = 1'b1;
        c_in = '0; c_in_v = 1'b0; c_out_rdy = 1'b1;
        a_wdata = '0; b_wdata = '0; c_wdata = '0;
        for (int a = 0; a < 4; a++) c_mem[a] = '0;
        for (int a = 0; a < 2; a++) b_mem[a] = '0;
        wm = '{'{1, 1, 1, 1}, '{1, 0, 0, 0}, '{0, 1, 0, 0}, '{2, 2, 2, 2}};
        build_a();

        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_signed();
        test_nf1_back_to_back();
        test_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
